mio_bus_responder: RTL and testbench

Memory/IO bus responder for the single-cycle CPU's MIO port. Accepts one CPU transaction at a time (request, address, write data, write enable), inserts a programmable number of wait states, and completes it against a local word-addressed data RAM, a GPIO output register or a free-running timer. It returns read data with a one-cycle ready pulse. It sits between the CPU core and the board peripherals in the top-level SoC.

---
 rtl/mio_bus_responder.sv | 152 +++++++++++++++
 tb/tb_mio_bus_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - MIO bus responder with wait states, data RAM, GPIO and timer
//
// Serves one CPU MIO transaction at a time. A request is latched on acceptance,
// held for WAIT_CYCLES wait states, then completed against the RAM (0x0), the
// GPIO register (0xE) or the free-running timer (0xF), selected by addr_in[31:28].
// Any other region is unmapped: reads return 0, writes are dropped, bus_err pulses.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req        transaction request; dropping it during wait states aborts the access
//   addr_in    byte address (bits [1:0] ignored)
//   wdata_in   write data
//   we         1 = write, 0 = read
//   rdata_out  registered read data, valid while ready=1
//   ready      one-cycle completion pulse
//   gpio_out   GPIO register contents
//   bus_err    one-cycle pulse alongside ready for unmapped addresses

module mio_bus_responder #(
   parameter int RAM_AW      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic        we,
   output logic [31:0] rdata_out,
   output logic        ready,
   output logic [31:0] gpio_out,
   output logic        bus_err
);

   localparam logic [7:0] WCNT_INIT = 8'(WAIT_CYCLES);
   localparam logic [3:0] RGN_RAM   = 4'h0;
   localparam logic [3:0] RGN_GPIO  = 4'hE;
   localparam logic [3:0] RGN_TIMER = 4'hF;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t            state_q;
   logic [7:0]        wcnt_q;
   logic [3:0]        rgn_q;
   logic [RAM_AW-1:0] idx_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic [31:0]       rdata_q;
   logic [31:0]       gpio_q;
   logic [31:0]       timer_q;
   logic              ready_q;
   logic              err_q;

   logic [31:0]       ram_mem [2**RAM_AW];

   logic              access_d;
   logic              unmapped_d;
   logic              ram_we_d;
   logic [31:0]       rdata_d;

   // Only the region nibble and the RAM word index are latched; the rest of the
   // address aliases onto the same word.
   logic              unused_addr;
   assign unused_addr = ^{addr_in[27:RAM_AW+2], addr_in[1:0]};

   always_comb begin
      access_d   = (state_q == ST_WAIT) && req && (wcnt_q == 8'd0);
      unmapped_d = !((rgn_q == RGN_RAM) || (rgn_q == RGN_GPIO) || (rgn_q == RGN_TIMER));
      // Gating with rst keeps a reset that lands on the access cycle from writing.
      ram_we_d   = access_d && we_q && (rgn_q == RGN_RAM) && !rst;
      rdata_d    = '0;
      if (!we_q) begin
         case (rgn_q)
            RGN_RAM:   rdata_d = ram_mem[idx_q];
            RGN_GPIO:  rdata_d = gpio_q;
            RGN_TIMER: rdata_d = timer_q;
            default:   rdata_d = '0;
         endcase
      end
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (ram_we_d) begin
         ram_mem[idx_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         rgn_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         gpio_q  <= '0;
         timer_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // Free-running; a timer write below overrides this increment on its edge.
         timer_q <= timer_q + 32'd1;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  rgn_q   <= addr_in[31:28];
                  idx_q   <= addr_in[RAM_AW+1:2];
                  wdata_q <= wdata_in;
                  we_q    <= we;
                  wcnt_q  <= WCNT_INIT;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state_q <= ST_IDLE;
               end else if (wcnt_q != 8'd0) begin
                  wcnt_q <= wcnt_q - 8'd1;
               end else begin
                  rdata_q <= rdata_d;
                  err_q   <= unmapped_d;
                  ready_q <= 1'b1;
                  if (we_q && (rgn_q == RGN_GPIO)) begin
                     gpio_q <= wdata_q;
                  end
                  if (we_q && (rgn_q == RGN_TIMER)) begin
                     timer_q <= wdata_q;
                  end
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rdata_out = rdata_q;
   assign ready     = ready_q;
   assign gpio_out  = gpio_q;
   assign bus_err   = err_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb/tb_mio_bus_responder.sv - randomized self-checking bench for mio_bus_responder

module tb_mio_bus_responder;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic        we;
   logic [31:0] rdata_out;
   logic        ready;
   logic [31:0] gpio_out;
   logic        bus_err;

   mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .addr_in   (addr_in),
      .wdata_in  (wdata_in),
      .we        (we),
      .rdata_out (rdata_out),
      .ready     (ready),
      .gpio_out  (gpio_out),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: sparse word memory, GPIO value, timer as load value plus
   // edges elapsed since the load edge.
   logic [31:0] mem_m [int];
   logic [9:0]  written_q [$];
   logic [31:0] gpio_m;
   logic [31:0] tbase;
   int          cbase;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 1'b0;
      gpio_m = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdata", rdata_out, 32'h0);
      check("rst_ready", {31'b0, ready}, 32'h0);
      check("rst_gpio", gpio_out, 32'h0);
      check("rst_err", {31'b0, bus_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      cbase = cyc;
      tbase = '0;
   endtask

   task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic w,
                      output logic [31:0] rd, output logic er, output int acc);
      int e0;
      int n;
      req = 1'b1; addr_in = a; wdata_in = d; we = w;
      @(posedge clk); #1;
      e0 = cyc;
      // Bus contents after acceptance must not matter.
      addr_in = $urandom; wdata_in = $urandom; we = 1'($urandom);
      n = 0;
      while (!ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(cyc - e0), 32'(W + 1));
      rd = rdata_out; er = bus_err; acc = cyc;
      req = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check("ready_width", {31'b0, ready}, 32'h0);
      check("err_width", {31'b0, bus_err}, 32'h0);
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] d, input logic w);
      logic [31:0] rd;
      logic [31:0] exp;
      logic        er;
      logic        mapped;
      int          acc;
      logic [3:0]  rg;
      logic [9:0]  idx;
      rg  = a[31:28];
      idx = a[11:2];
      txn(a, d, w, rd, er, acc);
      mapped = (rg == 4'h0) || (rg == 4'hE) || (rg == 4'hF);
      exp = '0;
      case (rg)
         4'h0:    if (!w) exp = mem_m[int'(idx)];
         4'hE:    exp = gpio_m;
         4'hF:    exp = tbase + 32'(acc - 1 - cbase);
         default: exp = '0;
      endcase
      check("bus_err", {31'b0, er}, {31'b0, !mapped});
      if (!mapped) check("unmapped_rdata", rd, 32'h0);
      else if (!w) check("rdata", rd, exp);
      if (w && mapped) begin
         case (rg)
            4'h0: begin
               mem_m[int'(idx)] = d;
               written_q.push_back(idx);
            end
            4'hE: gpio_m = d;
            default: begin
               tbase = d;
               cbase = acc;
            end
         endcase
      end
      check("gpio_out", gpio_out, gpio_m);
   endtask

   initial begin
      logic seen;
      int   n;
      rst = 1'b1; req = 1'b0; addr_in = '0; wdata_in = '0; we = 1'b0;
      do_reset();

      // First timer read reflects cycles since reset release.
      op(32'hF000_0000, 32'h0, 1'b0);

      // RAM write/read, aliasing onto the same word.
      op(32'h0000_0014, 32'h1234_5678, 1'b1);
      op(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
      op(32'h0000_0010, 32'h0, 1'b0);
      op(32'h0000_0014, 32'h0, 1'b0);
      op(32'h0ABC_0013, 32'h0, 1'b0);

      // GPIO.
      op(32'hE000_0000, 32'h0000_00A5, 1'b1);
      op(32'hE000_0004, 32'h0, 1'b0);

      // Timer load near wrap, then readback across the wrap.
      op(32'hF000_0000, 32'hFFFF_FFFE, 1'b1);
      op(32'hF000_0000, 32'h0, 1'b0);

      // Unmapped read and write leave state alone.
      op(32'h5000_0000, 32'h0, 1'b0);
      op(32'h5000_0000, 32'hCAFE_F00D, 1'b1);
      op(32'hF000_0008, 32'h0, 1'b0);
      op(32'h0000_0010, 32'h0, 1'b0);

      // Abort by dropping req in WAIT.
      op(32'h0000_0020, 32'h1111_2222, 1'b1);
      req = 1'b1; addr_in = 32'h0000_0020; wdata_in = 32'h5555_5555; we = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen = seen | ready;
      end
      check("abort_no_ready", {31'b0, seen}, 32'h0);
      op(32'h0000_0020, 32'h0, 1'b0);

      // Reset in the middle of WAIT.
      req = 1'b1; addr_in = 32'h0000_0020; wdata_in = 32'h7777_7777; we = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_wait_ready", {31'b0, ready}, 32'h0);
      do_reset();
      op(32'h0000_0020, 32'h0, 1'b0);

      // Reset while ready is high clears it at once.
      req = 1'b1; addr_in = 32'h5000_0000; wdata_in = 32'h0; we = 1'b1;
      n = 0;
      @(posedge clk); #1;
      while (!ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("resp_seen", {31'b0, ready}, 32'h1);
      rst = 1'b1;
      #1;
      check("rst_resp_ready", {31'b0, ready}, 32'h0);
      check("rst_resp_err", {31'b0, bus_err}, 32'h0);
      do_reset();

      // Randomized mix across all regions.
      for (int i = 0; i < 40; i++) begin
         int          r;
         logic [31:0] a;
         logic [31:0] d;
         logic        w;
         r = $urandom_range(0, 3);
         d = $urandom;
         w = 1'($urandom);
         case (r)
            0: begin
               if (written_q.size() == 0) w = 1'b1;
               if (w) a = {4'h0, 18'($urandom), 10'($urandom), 2'($urandom)};
               else   a = {4'h0, 18'($urandom), written_q[$urandom_range(0, written_q.size() - 1)], 2'($urandom)};
            end
            1:       a = {4'hE, 28'($urandom)};
            2:       a = {4'hF, 28'($urandom)};
            default: a = {4'($urandom_range(1, 13)), 28'($urandom)};
         endcase
         op(a, d, w);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
